// File: rtl/ysyx_23060124_wbu.sv
// Write-back unit: retires ALU/load results into the register file, tracks pending rd.
// Optional define YSYX_23060124_WB_BYPASS_EN adds write-port forwarding to the IDU sources.
module ysyx_23060124_wbu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [4:0]        i_rd,
  input  logic              i_rd_wen,
  input  logic              i_is_load,
  input  logic [DATA_W-1:0] i_result,
  input  logic              i_lsu_rvalid,
  input  logic [DATA_W-1:0] i_lsu_rdata,
  output logic              o_lsu_rready,
  output logic              o_rf_wen,
  output logic [4:0]        o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  input  logic              i_issue_valid,
  input  logic [4:0]        i_issue_rd,
  input  logic              i_issue_wen,
  input  logic [4:0]        i_raddr1,
  input  logic [4:0]        i_raddr2,
  output logic              o_stall,
  output logic              o_retire,
  output logic [31:0]       o_retire_cnt
`ifdef YSYX_23060124_WB_BYPASS_EN
  ,
  output logic              o_fwd1_valid,
  output logic              o_fwd2_valid,
  output logic [DATA_W-1:0] o_fwd1_data,
  output logic [DATA_W-1:0] o_fwd2_data
`endif
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        ld_rd_q;
  logic              ld_wen_q;
  logic              ld_start;
  logic              vld_p0;
  logic [4:0]        rd_p0;
  logic              wen_p0;
  logic [DATA_W-1:0] data_p0;
  logic              rf_wen_p0;
  logic [31:0]       set_mask, clr_mask;
  logic [31:0]       pending_q, pending_d;
  logic [31:0]       retire_cnt_q;

  // Stage p0: pick the retiring result (ALU in IDLE, LSU data in WAIT_LOAD)
  always_comb begin
    state_d      = state_q;
    o_ready      = 1'b0;
    o_lsu_rready = 1'b0;
    ld_start     = 1'b0;
    vld_p0       = 1'b0;
    rd_p0        = i_rd;
    wen_p0       = i_rd_wen;
    data_p0      = i_result;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          if (i_is_load) begin
            ld_start = 1'b1;
            state_d  = WAIT_LOAD;
          end else begin
            vld_p0 = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        o_lsu_rready = 1'b1;
        rd_p0        = ld_rd_q;
        wen_p0       = ld_wen_q;
        data_p0      = i_lsu_rdata;
        if (i_lsu_rvalid) begin
          vld_p0  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rf_wen_p0 = vld_p0 & wen_p0 & (rd_p0 != 5'd0);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (i_issue_valid && i_issue_wen && (i_issue_rd != 5'd0)) set_mask[i_issue_rd] = 1'b1;
    if (rf_wen_p0) clr_mask[rd_p0] = 1'b1;
    pending_d = ((pending_q & ~clr_mask) | set_mask) & ~32'h1;
  end

  always_ff @(posedge clk) begin
    if (ld_start) begin
      ld_rd_q  <= i_rd;
      ld_wen_q <= i_rd_wen;
    end
  end

  // Stage p1: registered register-file write port, retire pulse and counters
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      o_rf_wen     <= 1'b0;
      o_rf_waddr   <= '0;
      o_rf_wdata   <= '0;
      o_retire     <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      o_rf_wen  <= rf_wen_p0;
      o_retire  <= vld_p0;
      if (vld_p0) begin
        o_rf_waddr   <= rd_p0;
        o_rf_wdata   <= data_p0;
        retire_cnt_q <= retire_cnt_q + 32'd1;
      end
    end
  end

  assign o_retire_cnt = retire_cnt_q;

`ifdef YSYX_23060124_WB_BYPASS_EN
  assign o_fwd1_valid = o_rf_wen && (o_rf_waddr == i_raddr1) && (i_raddr1 != 5'd0);
  assign o_fwd2_valid = o_rf_wen && (o_rf_waddr == i_raddr2) && (i_raddr2 != 5'd0);
  assign o_fwd1_data  = o_rf_wdata;
  assign o_fwd2_data  = o_rf_wdata;
  assign o_stall      = (pending_q[i_raddr1] & ~o_fwd1_valid) | (pending_q[i_raddr2] & ~o_fwd2_valid);
`else
  assign o_stall      = pending_q[i_raddr1] | pending_q[i_raddr2];
`endif

endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// Bench for ysyx_23060124_wbu: directed scenarios then random traffic against a behavioural model.
module tb_ysyx_23060124_wbu;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_rd;
  logic        i_rd_wen;
  logic        i_is_load;
  logic [31:0] i_result;
  logic        i_lsu_rvalid;
  logic [31:0] i_lsu_rdata;
  logic        o_lsu_rready;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic        i_issue_wen;
  logic [4:0]  i_raddr1;
  logic [4:0]  i_raddr2;
  logic        o_stall;
  logic        o_retire;
  logic [31:0] o_retire_cnt;
`ifdef YSYX_23060124_WB_BYPASS_EN
  logic        o_fwd1_valid, o_fwd2_valid;
  logic [31:0] o_fwd1_data, o_fwd2_data;
`endif

  ysyx_23060124_wbu dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_rd(i_rd), .i_rd_wen(i_rd_wen), .i_is_load(i_is_load), .i_result(i_result),
    .i_lsu_rvalid(i_lsu_rvalid), .i_lsu_rdata(i_lsu_rdata), .o_lsu_rready(o_lsu_rready),
    .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd), .i_issue_wen(i_issue_wen),
    .i_raddr1(i_raddr1), .i_raddr2(i_raddr2), .o_stall(o_stall),
    .o_retire(o_retire), .o_retire_cnt(o_retire_cnt)
`ifdef YSYX_23060124_WB_BYPASS_EN
    , .o_fwd1_valid(o_fwd1_valid), .o_fwd2_valid(o_fwd2_valid),
    .o_fwd1_data(o_fwd1_data), .o_fwd2_data(o_fwd2_data)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: "is a load outstanding", which register it targets,
  // a per-register pending flag, and the expected write-port contents.
  bit        m_busy;
  bit [4:0]  m_ld_rd;
  bit        m_ld_wen;
  bit        m_pend [32];
  bit        m_wen, m_ret;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ld_rd = 0; m_ld_wen = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_wen = 0; m_ret = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0;
  endtask

  task automatic idle_in();
    i_valid = 0; i_rd = 0; i_rd_wen = 0; i_is_load = 0; i_result = 0;
    i_lsu_rvalid = 0; i_lsu_rdata = 0;
    i_issue_valid = 0; i_issue_rd = 0; i_issue_wen = 0;
    i_raddr1 = 0; i_raddr2 = 0;
  endtask

  // One clock: check combinational outputs, clock, then check registered outputs.
  task automatic step();
    bit ret, wr, ld, was_busy, f1, f2, iss;
    bit [4:0] rd, iss_rd, new_ld_rd;
    bit new_ld_wen;
    bit [31:0] d;
    #1;
    f1 = 0; f2 = 0;
`ifdef YSYX_23060124_WB_BYPASS_EN
    f1 = m_wen && (m_waddr == i_raddr1) && (i_raddr1 != 0);
    f2 = m_wen && (m_waddr == i_raddr2) && (i_raddr2 != 0);
    chk("fwd1_valid", o_fwd1_valid, f1);
    chk("fwd2_valid", o_fwd2_valid, f2);
    if (f1) chk("fwd1_data", o_fwd1_data, m_wdata);
    if (f2) chk("fwd2_data", o_fwd2_data, m_wdata);
`endif
    chk("ready", o_ready, !m_busy);
    chk("lsu_rready", o_lsu_rready, m_busy);
    chk("stall", o_stall, (m_pend[i_raddr1] && !f1) || (m_pend[i_raddr2] && !f2));
    was_busy = m_busy;
    if (m_busy) begin
      ret = i_lsu_rvalid; rd = m_ld_rd; wr = m_ld_wen; d = i_lsu_rdata; ld = 0;
    end else begin
      ret = i_valid && !i_is_load; rd = i_rd; wr = i_rd_wen; d = i_result;
      ld = i_valid && i_is_load;
    end
    iss = i_issue_valid && i_issue_wen && (i_issue_rd != 0);
    iss_rd = i_issue_rd; new_ld_rd = i_rd; new_ld_wen = i_rd_wen;
    @(posedge clk); #1;
    m_ret = ret;
    m_wen = ret && wr && (rd != 0);
    if (ret) begin m_waddr = rd; m_wdata = d; m_cnt = m_cnt + 1; end
    if (m_wen) m_pend[rd] = 0;
    if (iss) m_pend[iss_rd] = 1;
    if (ld) begin m_busy = 1; m_ld_rd = new_ld_rd; m_ld_wen = new_ld_wen; end
    else if (was_busy && ret) m_busy = 0;
    chk("rf_wen", o_rf_wen, m_wen);
    chk("retire", o_retire, m_ret);
    chk("rf_waddr", o_rf_waddr, m_waddr);
    chk("rf_wdata", o_rf_wdata, m_wdata);
    chk("retire_cnt", o_retire_cnt, m_cnt);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, o_ready, 1'b1);
    chk({tag, "_lsu_rready"}, o_lsu_rready, 1'b0);
    chk({tag, "_stall"}, o_stall, 1'b0);
    chk({tag, "_rf_wen"}, o_rf_wen, 1'b0);
    chk({tag, "_waddr"}, o_rf_waddr, 5'd0);
    chk({tag, "_wdata"}, o_rf_wdata, 32'd0);
    chk({tag, "_retire"}, o_retire, 1'b0);
    chk({tag, "_cnt"}, o_retire_cnt, 32'd0);
  endtask

  initial begin
    idle_in();
    i_rst_n = 1'b0;
    model_reset();
    #2;
    chk_reset_state("rst_during");
    @(posedge clk); @(negedge clk);
    i_raddr1 = 5; i_raddr2 = 7;
    #1 chk_reset_state("rst_hold");
    i_rst_n = 1'b1;
    idle_in();
    step();

    // ALU retirement of x5 with a pending-bit lifecycle
    i_issue_valid = 1; i_issue_rd = 5; i_issue_wen = 1;
    step();
    idle_in(); i_raddr1 = 5;
    step();
    i_valid = 1; i_rd = 5; i_rd_wen = 1; i_result = 32'h1234; i_raddr1 = 5;
    step();
    chk("alu_wen", o_rf_wen, 1'b1);
    chk("alu_waddr", o_rf_waddr, 5'd5);
    chk("alu_wdata", o_rf_wdata, 32'h1234);
    idle_in(); i_raddr1 = 5;
    step();
    chk("alu_unstall", o_stall, 1'b0);

    // Load to x7 answered three cycles later; EXU traffic must be refused meanwhile
    idle_in();
    i_valid = 1; i_is_load = 1; i_rd = 7; i_rd_wen = 1; i_result = 32'h5555_AAAA;
    i_issue_valid = 1; i_issue_rd = 7; i_issue_wen = 1;
    step();
    idle_in(); i_valid = 1; i_rd = 9; i_rd_wen = 1; i_result = 32'h99; i_raddr2 = 7;
    step();
    step();
    i_lsu_rvalid = 1; i_lsu_rdata = 32'hDEADBEEF;
    step();
    chk("ld_waddr", o_rf_waddr, 5'd7);
    chk("ld_wdata", o_rf_wdata, 32'hDEADBEEF);
    idle_in(); i_lsu_rvalid = 1; i_lsu_rdata = 32'h1; i_raddr2 = 7;
    step();
    chk("ld_idle_ready", o_ready, 1'b1);

    // RAW on x3, including issue and retire of x3 on the same edge
    idle_in(); i_issue_valid = 1; i_issue_rd = 3; i_issue_wen = 1;
    step();
    idle_in(); i_raddr1 = 3;
    step();
    i_valid = 1; i_rd = 3; i_rd_wen = 1; i_result = 32'h33;
    i_issue_valid = 1; i_issue_rd = 3; i_issue_wen = 1;
    step();
    idle_in(); i_raddr1 = 3;
    #1 chk("setwins_stall", o_stall, 1'b1);
    step();
    i_valid = 1; i_rd = 3; i_rd_wen = 1; i_result = 32'h34;
    step();
    idle_in(); i_raddr1 = 3;
    step();

    // rd = x0 retires without writing
    idle_in(); i_valid = 1; i_rd = 0; i_rd_wen = 1; i_result = 32'hFFFF;
    i_issue_valid = 1; i_issue_rd = 0; i_issue_wen = 1;
    step();
    chk("x0_wen", o_rf_wen, 1'b0);
    chk("x0_retire", o_retire, 1'b1);

    // Asynchronous reset while a load to x9 is outstanding
    idle_in(); i_valid = 1; i_is_load = 1; i_rd = 9; i_rd_wen = 1;
    i_issue_valid = 1; i_issue_rd = 9; i_issue_wen = 1;
    step();
    idle_in(); i_raddr1 = 9;
    #2 i_rst_n = 1'b0;
    #1 chk_reset_state("rst_wait");
    @(posedge clk); @(negedge clk);
    i_rst_n = 1'b1;
    model_reset();
    i_lsu_rvalid = 1; i_lsu_rdata = 32'hBAD0BAD0; i_raddr1 = 9;
    step();
    step();
    chk("rst_noload_wen", o_rf_wen, 1'b0);

    // Retire counter wrap
    idle_in();
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    chk("cnt_preset", o_retire_cnt, 32'hFFFF_FFFF);
    i_valid = 1; i_rd = 4; i_rd_wen = 1; i_result = 32'h44;
    step();
    chk("cnt_wrap", o_retire_cnt, 32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      i_valid       = ($urandom_range(0, 2) != 0);
      i_is_load     = ($urandom_range(0, 2) == 0);
      i_rd          = 5'($urandom_range(0, 7));
      i_rd_wen      = ($urandom_range(0, 3) != 0);
      i_result      = $urandom;
      i_lsu_rvalid  = $urandom_range(0, 1) == 1;
      i_lsu_rdata   = $urandom;
      i_issue_valid = $urandom_range(0, 1) == 1;
      i_issue_rd    = 5'($urandom_range(0, 7));
      i_issue_wen   = ($urandom_range(0, 3) != 0);
      i_raddr1      = 5'($urandom_range(0, 7));
      i_raddr2      = 5'($urandom_range(0, 31));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
